// File: rtl/leaf_stream_packetizer.sv
// Wraps user words into BFT packets for one output stream. Credits track free space in the
// receiver's buffer and are replenished by freespace-update packets addressed to this leaf.
module leaf_stream_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int SELF_LEAF             = 0,
    parameter int FIFO_DEPTH            = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
    input  logic                     vld_user2interface,
    output logic                     ack_interface2user,
    input  logic                     cfg_we,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
    input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
    input  logic                     resend,
    output logic [NUM_ADDR_BITS:0]   credits
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CRED_W   = NUM_ADDR_BITS + 1;
    localparam int PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;
    localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;
    localparam logic [CRED_W-1:0] CREDIT_MAX = CRED_W'(1 << NUM_ADDR_BITS);
    localparam logic [CRED_W:0]   UPDATE_INC = (CRED_W+1)'(FREESPACE_UPDATE_SIZE);

    logic [PAYLOAD_BITS-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]           fifo_fill;
    logic                     fifo_full, fifo_empty;
    logic                     push, emit, update_hit;
    logic [CRED_W-1:0]        credits_q, credits_d;
    logic [CRED_W:0]          credit_sum;
    logic [NUM_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [NUM_LEAF_BITS-1:0] dest_leaf_q, dest_leaf_d;
    logic [NUM_PORT_BITS-1:0] dest_port_q, dest_port_d;
    logic [PACKET_BITS-1:0]   dout_q, dout_d;
    logic                     unused_update_bits;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign fifo_fill  = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_fill == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);

    assign ack_interface2user = !fifo_full;
    assign push = vld_user2interface && !fifo_full;
    assign emit = !fifo_empty && (credits_q != '0) && !resend;

    assign update_hit = din_leaf_bft2interface[PACKET_BITS-1]
        && (din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS] == NUM_LEAF_BITS'(SELF_LEAF))
        && (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == '0);
    assign unused_update_bits = ^din_leaf_bft2interface[PORT_LSB-1:0];

    assign dout_leaf_interface2bft = dout_q;
    assign credits = credits_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_addr_d   = wr_addr_q;
        credits_d   = credits_q;
        dest_leaf_d = dest_leaf_q;
        dest_port_d = dest_port_q;
        dout_d      = '0;
        credit_sum  = {1'b0, credits_q};

        if (push) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end

        if (emit) begin
            rd_ptr_d  = rd_ptr_q + (PTR_W+1)'(1);
            wr_addr_d = wr_addr_q + NUM_ADDR_BITS'(1);
            dout_d    = {1'b1, dest_leaf_q, dest_port_q, wr_addr_q, fifo_mem[rd_ptr_q[PTR_W-1:0]]};
        end

        // Update and emit combine before saturating, so credits=1 plus an update lands at 64.
        if (update_hit) begin
            credit_sum = credit_sum + UPDATE_INC;
        end
        if (emit) begin
            credit_sum = credit_sum - (CRED_W+1)'(1);
        end
        if (!resend) begin
            if (credit_sum > {1'b0, CREDIT_MAX}) begin
                credits_d = CREDIT_MAX;
            end else begin
                credits_d = credit_sum[CRED_W-1:0];
            end
        end

        if (cfg_we) begin
            dest_leaf_d = cfg_dest_leaf;
            dest_port_d = cfg_dest_port;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_addr_q   <= '0;
            credits_q   <= CREDIT_MAX;
            dest_leaf_q <= '0;
            dest_port_q <= '0;
            dout_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_addr_q   <= wr_addr_d;
            credits_q   <= credits_d;
            dest_leaf_q <= dest_leaf_d;
            dest_port_q <= dest_port_d;
            dout_q      <= dout_d;
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= din_leaf_user2interface;
        end
    end

endmodule

// File: doc/leaf_stream_packetizer.md
# leaf_stream_packetizer

Transmit-side packetizer for one user output stream of a leaf. It accepts 32-bit words from a user kernel over the vld/ack handshake and wraps each word into a 49-bit BFT packet carrying destination leaf, destination port and receiver BRAM address. It enforces credit-based flow control against the receiver's buffer, and replenishes credits from freespace-update packets returned over the BFT. It sits between a user kernel output port and the leaf's outbound BFT link.

## Interface
Parameters:
- PACKET_BITS, 49, BFT packet width
- PAYLOAD_BITS, 32, user word width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, receiver BRAM address field width
- FREESPACE_UPDATE_SIZE, 64, credits added per freespace update
- SELF_LEAF, 0, this leaf's address, used to match incoming updates
- FIFO_DEPTH, 4, input buffer entries (power of two)

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous active-low reset
- din_leaf_user2interface  in  32  user word
- vld_user2interface  in  1  user word valid
- ack_interface2user  out  1  word accepted this cycle when high with vld
- cfg_we  in  1  load destination config
- cfg_dest_leaf  in  5  destination leaf
- cfg_dest_port  in  4  destination port
- din_leaf_bft2interface  in  49  incoming BFT packets (freespace updates)
- dout_leaf_interface2bft  out  49  outgoing BFT packet
- resend  in  1  hold/suppress output
- credits  out  8  current credit count (debug)

## Operation
- Packet format: [48] valid, [47:43] dest leaf, [42:39] dest port, [38:32] BRAM addr, [31:0] payload.
- Input FIFO, FIFO_DEPTH entries.
  - ack_interface2user = !full. It is derived from registered state only and never depends on vld.
  - A word is written on every cycle with vld && ack.
- Destination registers: loaded when cfg_we is high. Reset value is leaf 0, port 0.
- Credit counter:
  - Reset value is 2^NUM_ADDR_BITS = 128.
  - Decrements by 1 per emitted packet.
- Freespace update: an incoming packet with [48]=1, [47:43]=SELF_LEAF and [42:39]=0 adds FREESPACE_UPDATE_SIZE to the credit counter. Payload is ignored. The sum saturates at 128.
- Same-cycle update and emit: credit result = credits + FREESPACE_UPDATE_SIZE - 1, then saturated at 128.
- Emit condition: FIFO not empty && credits != 0 && !resend. When it holds:
  - pop the FIFO head;
  - register the packet as {1, dest_leaf, dest_port, wr_addr, head};
  - increment wr_addr (7 bits, wraps 127 -> 0).
- When the emit condition is false, the output register is loaded with 0.
- Resend: while resend is high, the output register is 0, nothing pops, and credits and wr_addr are frozen. The FIFO may still accept words while not full.
- Config change takes effect on the next emitted packet. Packets already in the output register are unchanged.

## Timing
- Reset (async assert, sync release) values:
  - dout_leaf_interface2bft = 0
  - ack_interface2user = 1
  - credits = 128
  - wr_addr = 0
  - FIFO empty
- Latency: a word accepted at edge k appears on dout after edge k+1, provided credits != 0 and resend is low at k+1. Same-cycle FIFO bypass is not allowed.
- Throughput: one packet per cycle sustained while credits last.
- Credit update from din sampled at edge k affects the emit decision at edge k+1.
- Full FIFO:
  - ack is low the cycle after the 4th unpopped write.
  - A pop and a write in the same cycle at full are impossible because ack=0.
  - At full, ack returns high the cycle after a pop.
- Empty FIFO with credits available: dout = 0, and no wr_addr change.
- Reset mid-stream: the FIFO contents are discarded, and credits and wr_addr are restored to their reset values immediately.

## Test plan
- Reset, then send 3 words 0xA0,0xA1,0xA2 with cfg leaf=5, port=3 -> three consecutive packets:
  - each has [48]=1, leaf 5, port 3;
  - addrs 0,1,2, payloads in order;
  - first packet appears one cycle after the first ack.
- Hold vld high with no credit returns for 200 words:
  - exactly 128 packets emitted, then dout=0;
  - FIFO fills and ack drops.
  - Then inject one update packet {1,SELF_LEAF,0,...} -> 64 more packets emitted, credits return to 0.
- Credits at 128 receive an update while idle -> credits stay 128 (saturation).
- Update arriving in the same cycle as an emit with credits=1 -> credits=64 the next cycle, and streaming continues without a gap.
- Assert resend for 5 cycles mid-stream:
  - dout=0 throughout;
  - no words are lost or duplicated;
  - addrs continue contiguously after resend deasserts.
- Send 130 packets with credits replenished -> wr_addr wraps 127->0 on the 129th packet.
- Deassert reset_n mid-stream -> dout=0 asynchronously, credits=128, and the next packet uses addr 0.
